saph_fpi_latfix: RTL and testbench
==================================

// Module: saph_fpi_latfix
// PURPOSE
//   FPU-side end of the saph_fpi interface: presents the fixed-latency responder contract the GPU expects
//   (d_trig/d_ready in, q_res exactly LATENCY cycles later) on top of a variable-latency, in-order FPU core
//   with valid/ready issue and a result strobe. Buffers early core results and releases each one on its
//   fixed-latency slot. Flags any core result that misses its slot.
// PARAMETERS
//   LATENCY    4       cycles from accepted trigger to q_res update; >=2; must equal saph_fpi latency
//   WIDTH      32      operand/result width
//   MODE_W     4       d_mode width
//   HAS_MODES  '1      MODE_W-bit... bitmask of supported modes, driven on has_modes (2**MODE_W bits)
//   DEPTH      4       max outstanding ops (accepted, not yet delivered); power of two, >=1
// PORTS
//   clk         in   1          clock
//   rst         in   1          synchronous reset, active high
//   d_trig      in   1          GPU issues op this cycle
//   d_lhs       in   WIDTH      left operand
//   d_rhs       in   WIDTH      right operand
//   d_mode      in   MODE_W     operation select
//   d_ready     out  1          responder can accept an op this cycle
//   q_res       out  WIDTH      result register, updated on delivery cycle, held otherwise
//   has_modes   out  2**MODE_W  constant HAS_MODES
//   c_valid     out  1          issue to core
//   c_ready     in   1          core accepts issue
//   c_lhs/c_rhs out  WIDTH      operands to core (combinational from d_lhs/d_rhs)
//   c_mode      out  MODE_W     mode to core (combinational from d_mode)
//   c_res_vld   in   1          core result strobe, results in issue order
//   c_res       in   WIDTH      core result
//   err_late    out  1          sticky: a slot came due with no buffered result
//   err_ovf     out  1          sticky: c_res_vld while result FIFO full
// BEHAVIOUR
//   - Reset: d_ready=0 during rst, q_res=0, err_late=0, err_ovf=0, inflight=0, FIFO empty,
//     delay line cleared. Core must share rst; no pre-reset result may be delivered after reset.
//   - d_ready = !rst && c_ready && (inflight < DEPTH), combinational. c_valid = d_trig && d_ready.
//   - Accept at cycle T: d_trig && d_ready. No ack if d_trig with d_ready=0: op is dropped, GPU must retry.
//   - Delay line: LATENCY-1 bit shift register; bit 0 loads accept flag, shifts each cycle.
//     Tap at end = "due"; q_res register loads on the due edge, so it is visible from T+LATENCY.
//   - Result FIFO: DEPTH entries, WIDTH wide; push on c_res_vld, pop on due. Push and pop same cycle
//     on empty FIFO: bypass, c_res goes straight to q_res (result arriving exactly in time is legal).
//   - Due with FIFO empty and no bypass: q_res <= 0, err_late <= 1, slot consumed (no later catch-up;
//     the stale result, if it arrives later, is pushed and delivered on the next slot -> order broken,
//     err_late stays set until rst).
//   - c_res_vld with FIFO full and no pop same cycle: result discarded, err_ovf <= 1.
//   - inflight: +1 on accept, -1 on due, unchanged on both; never exceeds DEPTH; width clog2(DEPTH+1).
//   - Back-to-back accepts each cycle deliver on consecutive cycles; q_res changes every cycle.
//   - Pointer wrap: FIFO read/write pointers are clog2(DEPTH)+1 bits; full = MSB differ, rest equal.
//   - No combinational path from c_res to q_res other than through the q_res register.
// TESTING
//   - Reset: hold rst 3 cycles mid-stream with 2 ops outstanding -> q_res=0, d_ready=0 during rst,
//     no q_res update for the dropped ops, inflight=0 after.
//   - Fixed latency: LATENCY=4, accept at T=10, core returns 0x3F800000 at T=11 -> q_res=0x3F800000
//     from T=14, unchanged T=15 onward, err flags 0.
//   - Just-in-time bypass: core returns 0x40000000 at T+3 exactly -> q_res=0x40000000 at T+4, err_late=0.
//   - Throughput/backpressure: DEPTH=4, c_ready=1, core delay 3, trig 8 consecutive cycles ->
//     d_ready never drops below needed, 8 results in order on 8 consecutive cycles.
//   - Capacity: core holds results, 4 accepts -> d_ready=0 on 5th cycle; c_ready=0 -> d_ready=0, c_valid=0.
//   - Late core: core delay 5 with LATENCY=4 -> q_res=0 at T+4, err_late=1 sticky until rst.

Source files
------------

// File: rtl/saph_fpi_latfix.sv
// saph_fpi_latfix: fixed-latency responder over a variable-latency, in-order FPU core
module saph_fpi_latfix #(
   parameter int                    LATENCY   = 4,
   parameter int                    WIDTH     = 32,
   parameter int                    MODE_W    = 4,
   parameter logic [2**MODE_W-1:0]  HAS_MODES = '1,
   parameter int                    DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 d_trig,
   input  logic [WIDTH-1:0]     d_lhs,
   input  logic [WIDTH-1:0]     d_rhs,
   input  logic [MODE_W-1:0]    d_mode,
   output logic                 d_ready,
   output logic [WIDTH-1:0]     q_res,
   output logic [2**MODE_W-1:0] has_modes,
   output logic                 c_valid,
   input  logic                 c_ready,
   output logic [WIDTH-1:0]     c_lhs,
   output logic [WIDTH-1:0]     c_rhs,
   output logic [MODE_W-1:0]    c_mode,
   input  logic                 c_res_vld,
   input  logic [WIDTH-1:0]     c_res,
   output logic                 err_late,
   output logic                 err_ovf
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] FULL_X = PW'(DEPTH);
   localparam logic [PW-1:0] IMASK = PW'(DEPTH - 1);
   logic [LATENCY-2:0] dl_q;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [PW-1:0]      wp_q, rp_q;
   logic [CW-1:0]      infl_q;
   logic [WIDTH-1:0]   q_res_q;
   logic               err_late_q, err_ovf_q;
   logic               acc, due, empty, full, pop, bypass, push;
   logic [IW-1:0]      widx, ridx;
   assign d_ready   = !rst && c_ready && (infl_q < CW'(DEPTH));
   assign acc       = d_trig && d_ready;
   assign c_valid   = acc;
   assign c_lhs     = d_lhs;
   assign c_rhs     = d_rhs;
   assign c_mode    = d_mode;
   assign has_modes = HAS_MODES;
   assign due       = dl_q[LATENCY-2];
   assign empty     = wp_q == rp_q;
   assign full      = (wp_q ^ rp_q) == FULL_X;
   assign pop       = due && !empty;
   assign bypass    = due && empty && c_res_vld;
   assign push      = c_res_vld && !bypass && (!full || pop);
   assign widx      = IW'(wp_q & IMASK);
   assign ridx      = IW'(rp_q & IMASK);
   assign q_res     = q_res_q;
   assign err_late  = err_late_q;
   assign err_ovf   = err_ovf_q;
   // result storage; contents are only meaningful between write and read pointers
   always_ff @(posedge clk) begin
      if (push) mem_q[widx] <= c_res;
   end
   // delay line, FIFO pointers, outstanding count, delivery register and sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_q       <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         infl_q     <= '0;
         q_res_q    <= '0;
         err_late_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         dl_q   <= (LATENCY-1)'({dl_q, acc});
         infl_q <= infl_q + CW'(acc) - CW'(due);
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         if (due) q_res_q <= pop ? mem_q[ridx] : bypass ? c_res : '0;
         if (due && empty && !c_res_vld) err_late_q <= 1'b1;
         if (c_res_vld && full && !pop) err_ovf_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_saph_fpi_latfix.sv
// tb_saph_fpi_latfix: scoreboard bench for the fixed-latency responder with a modelled core
module tb_saph_fpi_latfix;
   localparam int LAT = 4, W = 32, MW = 4, DEP = 4;
   typedef struct {
      logic [W-1:0] v;
      int           t;
      logic         late;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1, d_trig = 1'b0, c_ready = 1'b1, c_res_vld = 1'b0;
   logic [W-1:0] d_lhs = '0, d_rhs = '0, c_res = '0;
   logic [MW-1:0] d_mode = '0;
   logic d_ready, c_valid, err_late, err_ovf;
   logic [W-1:0] q_res, c_lhs, c_rhs;
   logic [MW-1:0] c_mode;
   logic [2**MW-1:0] has_modes;
   logic d_ready2, c_valid2, err_late2, err_ovf2;
   logic [W-1:0] q_res2, c_lhs2, c_rhs2;
   logic [MW-1:0] c_mode2;
   logic [2**MW-1:0] has_modes2;
   int checks = 0, errors = 0, cyc = 0, dly = 1, infl = 0;
   logic [W-1:0] exp_res = '0;
   logic exp_late = 1'b0, rdy2 = 1'b0;
   ent_t sb[$];
   ent_t core_q[$];

   saph_fpi_latfix #(.LATENCY(LAT), .WIDTH(W), .MODE_W(MW), .DEPTH(DEP)) dut (
      .clk(clk), .rst(rst), .d_trig(d_trig), .d_lhs(d_lhs), .d_rhs(d_rhs), .d_mode(d_mode),
      .d_ready(d_ready), .q_res(q_res), .has_modes(has_modes), .c_valid(c_valid), .c_ready(c_ready),
      .c_lhs(c_lhs), .c_rhs(c_rhs), .c_mode(c_mode), .c_res_vld(c_res_vld), .c_res(c_res),
      .err_late(err_late), .err_ovf(err_ovf));

   saph_fpi_latfix #(.LATENCY(LAT), .WIDTH(W), .MODE_W(MW), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .d_trig(d_trig), .d_lhs(d_lhs), .d_rhs(d_rhs), .d_mode(d_mode),
      .d_ready(d_ready2), .q_res(q_res2), .has_modes(has_modes2), .c_valid(c_valid2), .c_ready(c_ready),
      .c_lhs(c_lhs2), .c_rhs(c_rhs2), .c_mode(c_mode2), .c_res_vld(c_res_vld), .c_res(c_res),
      .err_late(err_late2), .err_ovf(err_ovf2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   // one clock cycle: drive core response, check handshake, advance, check delivery
   task automatic tick();
      logic er, acc;
      ent_t e;
      if (rst) core_q.delete();
      c_res_vld = core_q.size() > 0 && core_q[0].t == cyc;
      if (c_res_vld) begin
         e = core_q.pop_front();
         c_res = e.v;
      end else c_res = $urandom();
      #1;
      er  = !rst && c_ready && infl < DEP;
      acc = d_trig && er;
      chk("d_ready", d_ready, er);
      chk("c_valid", c_valid, acc);
      rdy2 = d_ready2;
      if (acc) begin
         e.v = d_lhs + d_rhs;
         e.t = cyc + dly;
         e.late = 1'b0;
         core_q.push_back(e);
         e.t = cyc + LAT;
         e.late = dly > LAT - 1;
         sb.push_back(e);
         infl++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         sb.delete();
         infl = 0;
         exp_res = '0;
         exp_late = 1'b0;
      end else if (sb.size() > 0 && sb[0].t == cyc) begin
         e = sb.pop_front();
         infl--;
         exp_res = e.late ? '0 : e.v;
         if (e.late) exp_late = 1'b1;
      end
      chk("q_res", q_res, exp_res);
      chk("err_late", err_late, exp_late);
      chk("err_ovf", err_ovf, 0);
   endtask

   task automatic op(input logic [W-1:0] l, input logic [W-1:0] r);
      d_trig = 1'b1;
      d_lhs = l;
      d_rhs = r;
      tick();
      d_trig = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [4:0] cap_exp;
      // reset
      tick();
      tick();
      rst = 1'b0;
      chk("has_modes", has_modes, 16'hFFFF);
      d_lhs = 32'h1234_5678;
      d_rhs = 32'h9ABC_DEF0;
      d_mode = 4'hA;
      #1;
      chk("c_lhs", c_lhs, 32'h1234_5678);
      chk("c_rhs", c_rhs, 32'h9ABC_DEF0);
      chk("c_mode", c_mode, 4'hA);
      // fixed latency through the FIFO
      dly = 1;
      op(32'h3F80_0000, 0);
      idle(7);
      // just-in-time bypass
      dly = 3;
      op(32'h4000_0000, 0);
      idle(6);
      // back-to-back, all bypass
      for (int i = 0; i < 8; i++) op(32'h100 * i, i + 1);
      idle(6);
      // back-to-back with results buffered
      dly = 1;
      for (int i = 0; i < 5; i++) op(32'hA500_0000 + i, 32'h10);
      idle(6);
      // reset with two ops outstanding
      dly = 2;
      op(32'h11, 1);
      op(32'h22, 2);
      rst = 1'b1;
      d_trig = 1'b1;
      idle(3);
      d_trig = 1'b0;
      rst = 1'b0;
      idle(6);
      op(32'h33, 3);
      idle(5);
      // capacity on the two-deep instance
      dly = 3;
      cap_exp = 5'b10011;
      for (int i = 0; i < 5; i++) begin
         op(32'h500 + i, 0);
         chk("cap_ready2", rdy2, cap_exp[i]);
      end
      idle(6);
      // core back-pressure
      c_ready = 1'b0;
      op(32'h77, 0);
      op(32'h78, 0);
      c_ready = 1'b1;
      idle(5);
      // late core
      dly = 5;
      op(32'h5555_0000, 0);
      idle(8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
